// File: rtl/synth_pkg.sv
// Shared definitions for the voice mixer: FSM state encoding and a
// constant-foldable ceil(log2) helper used for derived widths.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_OUT   = 3'd5
  } mix_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/voice_mixer.sv
// Sums gain-scaled voice samples into one saturated output per frame, sharing
// a single external multi-cycle multiplier through its trigger/ready/done handshake.
module voice_mixer
  import synth_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int NUM_VOICES  = 8,
  parameter int MUL_TIMEOUT = 255
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  input  logic [NUM_VOICES*C_WIDTH-1:0] sample_in,
  input  logic [NUM_VOICES*C_WIDTH-1:0] gain_in,
  input  logic [NUM_VOICES-1:0]         voice_en,
  output logic                          busy,
  output logic [C_WIDTH-1:0]            mix_out,
  output logic                          mix_valid,
  output logic                          clip,
  output logic                          frame_drop,
  output logic                          mul_err,
  output logic [C_WIDTH-1:0]            mul_a,
  output logic [C_WIDTH-1:0]            mul_b,
  output logic                          mul_trigger,
  input  logic                          mul_ready,
  input  logic                          mul_done,
  input  logic [C_WIDTH-1:0]            mul_y
);

  localparam int VOICE_W = clog2(NUM_VOICES);
  localparam int ACC_W   = C_WIDTH + VOICE_W;
  localparam int IDX_W   = (VOICE_W > 0) ? VOICE_W : 1;
  localparam int CNT_W   = clog2(MUL_TIMEOUT + 1);

  localparam logic [ACC_W-1:0] SAT_MAX   = ACC_W'({C_WIDTH{1'b1}});
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MUL_TIMEOUT - 1);

  // The gain scaling itself lives in the multiplier; FIXED_POINT only has to agree with it.
  generate
    if (NUM_VOICES < 1 || NUM_VOICES > 64 || FIXED_POINT >= C_WIDTH || MUL_TIMEOUT < 1) begin : g_param_check
      $error("voice_mixer: parameter out of range");
    end
  endgenerate

  mix_state_t state_reg, state_next;

  logic [NUM_VOICES*C_WIDTH-1:0] sample_buf_reg;
  logic [NUM_VOICES*C_WIDTH-1:0] gain_buf_reg;
  logic [NUM_VOICES-1:0]         en_buf_reg;
  logic [ACC_W-1:0]              acc_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic [CNT_W-1:0]              cnt_reg;
  logic                          busy_reg;
  logic [C_WIDTH-1:0]            mix_out_reg;
  logic                          mix_valid_reg;
  logic                          clip_reg;
  logic                          frame_drop_reg;
  logic                          mul_err_reg;

  logic accept;
  logic cnt_clear;
  logic acc_add;
  logic idx_inc;
  logic do_out;
  logic abort;
  logic trigger;

  logic [C_WIDTH-1:0] sample_arr [NUM_VOICES];
  logic [C_WIDTH-1:0] gain_arr   [NUM_VOICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_unpack
      assign sample_arr[gi] = sample_buf_reg[gi*C_WIDTH +: C_WIDTH];
      assign gain_arr[gi]   = gain_buf_reg[gi*C_WIDTH +: C_WIDTH];
    end
  endgenerate

  // Operands follow the buffered voice index, so they hold through ISSUE and WAIT.
  assign mul_a       = sample_arr[idx_reg];
  assign mul_b       = gain_arr[idx_reg];
  assign mul_trigger = trigger;

  assign busy       = busy_reg;
  assign mix_out    = mix_out_reg;
  assign mix_valid  = mix_valid_reg;
  assign clip       = clip_reg;
  assign frame_drop = frame_drop_reg;
  assign mul_err    = mul_err_reg;

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    cnt_clear  = 1'b0;
    acc_add    = 1'b0;
    idx_inc    = 1'b0;
    do_out     = 1'b0;
    abort      = 1'b0;
    trigger    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (frame_valid) begin
          accept     = 1'b1;
          state_next = ST_SEL;
        end
      end
      ST_SEL: begin
        if (en_buf_reg[idx_reg]) begin
          cnt_clear  = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_NEXT;
        end
      end
      ST_ISSUE: begin
        if (mul_ready) begin
          trigger    = 1'b1;
          cnt_clear  = 1'b1;
          state_next = ST_WAIT;
        end else if (cnt_reg == CNT_LIMIT) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mul_done) begin
          acc_add    = 1'b1;
          state_next = ST_NEXT;
        end else if (cnt_reg == CNT_LIMIT) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (idx_reg == LAST_IDX) begin
          state_next = ST_OUT;
        end else begin
          idx_inc    = 1'b1;
          state_next = ST_SEL;
        end
      end
      ST_OUT: begin
        do_out     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      sample_buf_reg <= '0;
      gain_buf_reg   <= '0;
      en_buf_reg     <= '0;
      acc_reg        <= '0;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      mix_out_reg    <= '0;
      mix_valid_reg  <= 1'b0;
      clip_reg       <= 1'b0;
      frame_drop_reg <= 1'b0;
      mul_err_reg    <= 1'b0;
    end else begin
      frame_drop_reg <= frame_valid && (state_reg != ST_IDLE);
      mix_valid_reg  <= do_out;

      if (accept) begin
        sample_buf_reg <= sample_in;
        gain_buf_reg   <= gain_in;
        en_buf_reg     <= voice_en;
        acc_reg        <= '0;
        idx_reg        <= '0;
        busy_reg       <= 1'b1;
      end

      if (acc_add) begin
        acc_reg <= acc_reg + ACC_W'(mul_y);
      end

      if (idx_inc) begin
        idx_reg <= idx_reg + 1'b1;
      end

      if (cnt_clear) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_ISSUE || state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // The accumulator is wide enough to never wrap, so one compare decides saturation.
      if (do_out) begin
        busy_reg <= 1'b0;
        if (acc_reg > SAT_MAX) begin
          mix_out_reg <= '1;
          clip_reg    <= 1'b1;
        end else begin
          mix_out_reg <= acc_reg[C_WIDTH-1:0];
          clip_reg    <= 1'b0;
        end
      end

      if (abort) begin
        busy_reg    <= 1'b0;
        mul_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: a behavioural Q8 multiplier stub with
// random handshake latencies, plus a reference mix computed from plain arithmetic.
module tb_voice_mixer;

  localparam int CW  = 16;
  localparam int FP  = 8;
  localparam int NV  = 4;
  localparam int TMO = 20;

  logic              ctl_clk = 1'b0;
  logic              reset;
  logic              frame_valid;
  logic [NV*CW-1:0]  sample_in;
  logic [NV*CW-1:0]  gain_in;
  logic [NV-1:0]     voice_en;
  logic              busy;
  logic [CW-1:0]     mix_out;
  logic              mix_valid;
  logic              clip;
  logic              frame_drop;
  logic              mul_err;
  logic [CW-1:0]     mul_a;
  logic [CW-1:0]     mul_b;
  logic              mul_trigger;
  logic              mul_ready;
  logic              mul_done;
  logic [CW-1:0]     mul_y;

  int tests_run    = 0;
  int tests_failed = 0;
  int trig_count   = 0;
  int mv_count     = 0;
  int drop_count   = 0;
  int op_unstable  = 0;

  bit stub_never_done = 0;
  bit stub_stray      = 0;
  bit stub_slow       = 0;
  logic      stub_busy;
  int        stub_cnt;
  logic [CW-1:0] cap_a, cap_b;
  logic [CW-1:0] cap_a_q[$];
  logic [CW-1:0] cap_b_q[$];

  always #5 ctl_clk = ~ctl_clk;

  voice_mixer #(
    .C_WIDTH(CW), .FIXED_POINT(FP), .NUM_VOICES(NV), .MUL_TIMEOUT(TMO)
  ) dut (
    .ctl_clk(ctl_clk), .reset(reset), .frame_valid(frame_valid),
    .sample_in(sample_in), .gain_in(gain_in), .voice_en(voice_en),
    .busy(busy), .mix_out(mix_out), .mix_valid(mix_valid), .clip(clip),
    .frame_drop(frame_drop), .mul_err(mul_err), .mul_a(mul_a), .mul_b(mul_b),
    .mul_trigger(mul_trigger), .mul_ready(mul_ready), .mul_done(mul_done), .mul_y(mul_y)
  );

  function automatic logic [CW-1:0] q8_product(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [2*CW-1:0] p;
    p = a * b;
    return p[FP +: CW];
  endfunction

  // Multiplier stand-in: random ready gaps, random done latency, optional stray done pulses.
  always @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      mul_ready <= 1'b0;
      mul_done  <= 1'b0;
      mul_y     <= '0;
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      mul_done <= 1'b0;
      if (!stub_busy) begin
        if (mul_trigger === 1'b1) begin
          cap_a <= mul_a;
          cap_b <= mul_b;
          cap_a_q.push_back(mul_a);
          cap_b_q.push_back(mul_b);
          stub_busy <= 1'b1;
          mul_ready <= 1'b0;
          stub_cnt  <= stub_slow ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 4));
        end else begin
          mul_ready <= ($urandom_range(0, 2) != 0);
          if (stub_stray && $urandom_range(0, 3) == 0) begin
            mul_done <= 1'b1;
            mul_y    <= CW'($urandom);
          end
        end
      end else if (stub_never_done) begin
        mul_ready <= 1'b0;
      end else if (stub_cnt == 0) begin
        if (mul_a !== cap_a || mul_b !== cap_b) op_unstable++;
        mul_done  <= 1'b1;
        mul_y     <= q8_product(cap_a, cap_b);
        stub_busy <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  always @(posedge ctl_clk) begin
    if (mul_trigger === 1'b1) trig_count++;
    if (mix_valid === 1'b1) mv_count++;
    if (frame_drop === 1'b1) drop_count++;
  end

  // Reference: saturating sum of Q8-scaled, width-truncated products of the enabled voices.
  function automatic void ref_mix(input logic [NV*CW-1:0] s, input logic [NV*CW-1:0] g,
                                  input logic [NV-1:0] en, output logic [CW-1:0] m, output logic c);
    longint total;
    longint a;
    longint b;
    total = 0;
    for (int v = 0; v < NV; v++) begin
      if (en[v]) begin
        a = longint'(s[v*CW +: CW]);
        b = longint'(g[v*CW +: CW]);
        total += ((a * b) / (longint'(1) << FP)) % (longint'(1) << CW);
      end
    end
    if (total > (longint'(1) << CW) - 1) begin
      m = '1;
      c = 1'b1;
    end else begin
      m = CW'(total);
      c = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge ctl_clk);
    #1;
  endtask

  // Drives one frame and waits (bounded) for its mix_valid; cycles counts strobe and pulse cycles inclusively.
  task automatic run_frame(input logic [NV*CW-1:0] s, input logic [NV*CW-1:0] g, input logic [NV-1:0] en,
                           output logic [CW-1:0] m, output logic c, output int trigs,
                           output int cycles, output bit ok);
    int t0;
    t0 = trig_count;
    cap_a_q.delete();
    cap_b_q.delete();
    sample_in   = s;
    gain_in     = g;
    voice_en    = en;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    cycles = 2;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (mix_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
      cycles++;
    end
    m = mix_out;
    c = clip;
    trigs = trig_count - t0;
  endtask

  function automatic logic [NV*CW-1:0] rand_vec(input int max_val);
    logic [NV*CW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*CW +: CW] = CW'($urandom_range(0, max_val));
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    frame_valid = 1'b0;
    sample_in = '0;
    gain_in = '0;
    voice_en = '0;
    repeat (3) tick();
    tests_run++;
    if ({busy, mix_valid, clip, frame_drop, mul_err, mul_trigger} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, want 000000", {busy, mix_valid, clip, frame_drop, mul_err, mul_trigger});
    end
    tests_run++;
    if ({mix_out, mul_a, mul_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: mix_out=%h mul_a=%h mul_b=%h, want 0", mix_out, mul_a, mul_b);
    end
    reset = 1'b0;
    tick();
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_basic();
    logic [CW-1:0] m; logic c; int tr, cy; bit ok;
    run_frame({16'd400, 16'd300, 16'd200, 16'd100}, {4{16'h0100}}, 4'hF, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== 16'd1000 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_mix: ok=%0d mix=%0d clip=%b, want mix=1000 clip=0", ok, m, c);
    end
    tests_run++;
    if (tr !== 4) begin
      tests_failed++;
      $display("FAIL basic_triggers: got %0d, want 4", tr);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_busy_drop: busy=%b with mix_valid, want 0", busy);
    end
    tick();
    tests_run++;
    if (mix_valid !== 1'b0 || mix_out !== 16'd1000) begin
      tests_failed++;
      $display("FAIL basic_pulse: mix_valid=%b mix_out=%0d, want 0 and held 1000", mix_valid, mix_out);
    end
    $display("[TB] basic: mix=%0d clip=%b triggers=%0d", m, c, tr);
  endtask

  task automatic test_single();
    logic [CW-1:0] m; logic c; int tr, cy; bit ok;
    logic [NV*CW-1:0] s, g;
    s = rand_vec(16'hFFFF);
    g = rand_vec(16'h0300);
    s[0 +: CW] = 16'h1000;
    g[0 +: CW] = 16'h0080;
    run_frame(s, g, 4'h1, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== 16'h0800 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_mix: ok=%0d mix=%h clip=%b, want 0800 clip=0", ok, m, c);
    end
    tests_run++;
    if (tr !== 1 || cap_a_q.size() != 1 || cap_a_q[0] !== 16'h1000 || cap_b_q[0] !== 16'h0080) begin
      tests_failed++;
      $display("FAIL single_operands: triggers=%0d, want 1 with a=1000 b=0080", tr);
    end
    $display("[TB] single: mix=%h triggers=%0d", m, tr);
  endtask

  task automatic test_clip();
    logic [CW-1:0] m; logic c; int tr, cy; bit ok;
    run_frame({4{16'hC000}}, {4{16'h0100}}, 4'hF, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== 16'hFFFF || c !== 1'b1) begin
      tests_failed++;
      $display("FAIL clip_sat: ok=%0d mix=%h clip=%b, want FFFF clip=1", ok, m, c);
    end
    $display("[TB] clip: mix=%h clip=%b", m, c);
    run_frame({16'd2, 16'd1, 16'd1, 16'd1}, {4{16'h0100}}, 4'hF, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== 16'd5 || c !== 1'b0) begin
      tests_failed++;
      $display("FAIL clip_release: ok=%0d mix=%0d clip=%b, want 5 clip=0", ok, m, c);
    end
    $display("[TB] clip release: mix=%0d clip=%b", m, c);
  endtask

  task automatic test_no_voices();
    logic [CW-1:0] m; logic c; int tr, cy; bit ok;
    run_frame(rand_vec(16'hFFFF), rand_vec(16'hFFFF), 4'h0, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== '0 || c !== 1'b0 || tr !== 0) begin
      tests_failed++;
      $display("FAIL no_voices: ok=%0d mix=%h clip=%b triggers=%0d, want 0/0/0", ok, m, c, tr);
    end
    tests_run++;
    if (cy !== 3 + 2 * NV) begin
      tests_failed++;
      $display("FAIL no_voices_latency: got %0d cycles, want %0d", cy, 3 + 2 * NV);
    end
    $display("[TB] no voices: mix=%0d latency=%0d", m, cy);
  endtask

  task automatic test_drop();
    logic [NV*CW-1:0] sa, ga;
    logic [CW-1:0] em; logic ec;
    int mv0;
    bit ok;
    sa = rand_vec(16'h3FFF);
    ga = rand_vec(16'h0100);
    ref_mix(sa, ga, 4'hF, em, ec);
    sample_in = sa; gain_in = ga; voice_en = 4'hF;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    mv0 = mv_count;
    tick(); tick();
    sample_in = rand_vec(16'hFFFF); gain_in = rand_vec(16'hFFFF); voice_en = 4'h5;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tests_run++;
    if (frame_drop !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_pulse: frame_drop=%b, want 1", frame_drop);
    end
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (mix_valid === 1'b1) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok || mix_out !== em || clip !== ec) begin
      tests_failed++;
      $display("FAIL drop_result: ok=%0d mix=%h clip=%b, want %h clip=%b", ok, mix_out, clip, em, ec);
    end
    repeat (60) tick();
    tests_run++;
    if (mv_count - mv0 !== 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_no_second_frame: mix_valid pulses=%0d busy=%b, want 1 and 0", mv_count - mv0, busy);
    end
    $display("[TB] drop: mix=%h clip=%b", mix_out, clip);
  endtask

  task automatic test_random();
    logic [NV*CW-1:0] s, g;
    logic [NV-1:0] en;
    logic [CW-1:0] m, em; logic c, ec; int tr, cy; bit ok, ops_ok;
    int k;
    stub_stray = 1;
    for (int it = 0; it < 24; it++) begin
      if (it % 2 == 0) begin
        s = rand_vec(16'h1FFF);
        g = rand_vec(16'h0100);
      end else begin
        s = rand_vec(16'hFFFF);
        g = rand_vec(16'h0300);
      end
      en = NV'($urandom);
      ref_mix(s, g, en, em, ec);
      run_frame(s, g, en, m, c, tr, cy, ok);
      ops_ok = (cap_a_q.size() == $countones(en));
      k = 0;
      for (int v = 0; v < NV; v++) begin
        if (en[v] && ops_ok) begin
          if (cap_a_q[k] !== s[v*CW +: CW] || cap_b_q[k] !== g[v*CW +: CW]) ops_ok = 0;
          k++;
        end
      end
      tests_run++;
      if (!ok || m !== em || c !== ec || tr !== $countones(en) || !ops_ok) begin
        tests_failed++;
        $display("FAIL random_%0d: ok=%0d mix=%h clip=%b trig=%0d ops=%0d, want mix=%h clip=%b trig=%0d",
                 it, ok, m, c, tr, ops_ok, em, ec, $countones(en));
      end
      $display("[TB] random %0d: en=%b mix=%h clip=%b triggers=%0d", it, en, m, c, tr);
    end
    stub_stray = 0;
    tests_run++;
    if (op_unstable !== 0) begin
      tests_failed++;
      $display("FAIL operand_stability: %0d changes between trigger and done, want 0", op_unstable);
    end
  endtask

  task automatic test_back_to_back();
    logic [NV*CW-1:0] s, g;
    logic [CW-1:0] m, em; logic c, ec; int tr, cy; bit ok;
    int d0;
    d0 = drop_count;
    for (int it = 0; it < 2; it++) begin
      s = rand_vec(16'h2FFF);
      g = rand_vec(16'h0180);
      ref_mix(s, g, 4'hF, em, ec);
      run_frame(s, g, 4'hF, m, c, tr, cy, ok);
      tests_run++;
      if (!ok || m !== em || c !== ec) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d: ok=%0d mix=%h clip=%b, want %h clip=%b", it, ok, m, c, em, ec);
      end
      $display("[TB] back-to-back %0d: mix=%h clip=%b", it, m, c);
    end
    tick();
    tests_run++;
    if (drop_count !== d0) begin
      tests_failed++;
      $display("FAIL back_to_back_drop: %0d drops, want 0", drop_count - d0);
    end
  endtask

  task automatic test_timeout();
    logic [CW-1:0] m_prev;
    int mv0, cy;
    bit done_ok;
    m_prev = mix_out;
    mv0 = mv_count;
    stub_never_done = 1;
    sample_in = rand_vec(16'hFFFF); gain_in = rand_vec(16'h0100); voice_en = 4'hF;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    cy = 1;
    done_ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) begin done_ok = 1; break; end
      tick();
      cy++;
    end
    tick();
    tests_run++;
    if (!done_ok || cy < TMO + 2) begin
      tests_failed++;
      $display("FAIL timeout_abort: ended=%0d busy_cycles=%0d, want ended after at least %0d", done_ok, cy, TMO + 2);
    end
    tests_run++;
    if (mul_err !== 1'b1 || mv_count !== mv0 || mix_out !== m_prev) begin
      tests_failed++;
      $display("FAIL timeout_state: mul_err=%b pulses=%0d mix=%h, want 1, 0, held %h", mul_err, mv_count - mv0, mix_out, m_prev);
    end
    stub_never_done = 0;
    repeat (10) tick();
    tests_run++;
    if (mul_err !== 1'b1 || busy !== 1'b0 || mv_count !== mv0) begin
      tests_failed++;
      $display("FAIL timeout_sticky: mul_err=%b busy=%b pulses=%0d, want 1/0/0", mul_err, busy, mv_count - mv0);
    end
    $display("[TB] timeout: mul_err=%b busy_cycles=%0d", mul_err, cy);
  endtask

  task automatic test_reset_mid_frame();
    logic [NV*CW-1:0] s, g;
    logic [CW-1:0] m, em; logic c, ec; int tr, cy, t0; bit ok, seen;
    stub_slow = 1;
    t0 = trig_count;
    sample_in = {4{16'h0400}}; gain_in = {4{16'h0100}}; voice_en = 4'hF;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trig_count != t0) begin seen = 1; break; end
    end
    tick();
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (!seen || {busy, mix_valid, clip, frame_drop, mul_err, mul_trigger} !== 6'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_flags: in_wait=%0d flags=%b, want 000000", seen,
               {busy, mix_valid, clip, frame_drop, mul_err, mul_trigger});
    end
    tests_run++;
    if ({mix_out, mul_a, mul_b} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_data: mix_out=%h mul_a=%h mul_b=%h, want 0", mix_out, mul_a, mul_b);
    end
    tick();
    reset = 1'b0;
    stub_slow = 0;
    tick();
    s = rand_vec(16'h1FFF);
    g = rand_vec(16'h0200);
    ref_mix(s, g, 4'hB, em, ec);
    run_frame(s, g, 4'hB, m, c, tr, cy, ok);
    tests_run++;
    if (!ok || m !== em || c !== ec || tr !== 3) begin
      tests_failed++;
      $display("FAIL mid_reset_fresh: ok=%0d mix=%h clip=%b trig=%0d, want %h clip=%b trig=3", ok, m, c, tr, em, ec);
    end
    $display("[TB] reset mid-frame: fresh mix=%h clip=%b", m, c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_clip();
    test_no_voices();
    test_drop();
    test_random();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
